// File: rtl/vdg_timing.sv
// Raster timing and display-fetch sequencer: pixel/line counters, sync, display enable,
// VRAM fetch strobe/address and character row count for the pixel data switch.
module vdg_timing #(
  parameter int H_ACTIVE     = 256,
  parameter int H_TOTAL      = 320,
  parameter int H_SYNC_START = 280,
  parameter int H_SYNC_LEN   = 24,
  parameter int V_ACTIVE     = 192,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC_START = 225,
  parameter int V_SYNC_LEN   = 3,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AnG,
  input  logic [3:0]        mode,
  output logic              load,
  output logic [3:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              de,
  output logic              HS_n,
  output logic              FS_n
);

  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_LINE_END = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] HS_LO      = H_W'(H_SYNC_START);
  localparam logic [H_W-1:0] HS_HI      = H_W'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] VS_LO      = V_W'(V_SYNC_START);
  localparam logic [V_W-1:0] VS_HI      = V_W'(V_SYNC_START + V_SYNC_LEN);

  // Bytes per line follow the active width: one byte per 8 or per 16 pixels.
  localparam logic [ADDR_W-1:0] BPL_WIDE   = ADDR_W'(H_ACTIVE / 8);
  localparam logic [ADDR_W-1:0] BPL_NARROW = ADDR_W'(H_ACTIVE / 16);

  logic [H_W-1:0]    h_count_reg;
  logic [V_W-1:0]    v_count_reg;
  logic              ang_reg;
  logic [2:0]        gm_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic [3:0]        rep_cnt_reg;

  logic              load_reg;
  logic [3:0]        row_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              de_reg;
  logic              hs_n_reg;
  logic              fs_n_reg;

  logic              wide;
  logic [3:0]        rep_last;
  logic [ADDR_W-1:0] bpl;
  logic              active;
  logic              load_now;
  logic              line_end;
  logic              h_last;
  logic              v_last;
  logic              hsync_on;
  logic              fsync_on;
  logic              unused_mode0;

  assign unused_mode0 = mode[0];

  always_comb begin
    wide     = 1'b1;
    rep_last = 4'd11;
    if (ang_reg) begin
      case (gm_reg)
        3'b000, 3'b001: begin wide = 1'b0; rep_last = 4'd2; end
        3'b010:         begin wide = 1'b1; rep_last = 4'd2; end
        3'b011:         begin wide = 1'b0; rep_last = 4'd1; end
        3'b100:         begin wide = 1'b1; rep_last = 4'd1; end
        3'b101:         begin wide = 1'b0; rep_last = 4'd0; end
        default:        begin wide = 1'b1; rep_last = 4'd0; end
      endcase
    end
  end

  assign bpl      = wide ? BPL_WIDE : BPL_NARROW;
  assign active   = (h_count_reg < H_ACT) && (v_count_reg < V_ACT);
  assign load_now = active && (wide ? (h_count_reg[2:0] == 3'd0) : (h_count_reg[3:0] == 4'd0));
  assign line_end = (v_count_reg < V_ACT) && (h_count_reg == H_LINE_END);
  assign h_last   = (h_count_reg == H_LAST);
  assign v_last   = (v_count_reg == V_LAST);
  assign hsync_on = (h_count_reg >= HS_LO) && (h_count_reg < HS_HI);
  assign fsync_on = (v_count_reg >= VS_LO) && (v_count_reg < VS_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_reg   <= '0;
      v_count_reg   <= '0;
      ang_reg       <= AnG;
      gm_reg        <= mode[3:1];
      line_base_reg <= '0;
      addr_cnt_reg  <= '0;
      rep_cnt_reg   <= '0;
      load_reg      <= 1'b0;
      row_reg       <= 4'd0;
      addr_reg      <= '0;
      de_reg        <= 1'b0;
      hs_n_reg      <= 1'b1;
      fs_n_reg      <= 1'b1;
    end else begin
      if (h_last) begin
        h_count_reg <= '0;
        v_count_reg <= v_last ? '0 : v_count_reg + 1'b1;
      end else begin
        h_count_reg <= h_count_reg + 1'b1;
      end

      // Field wrap outranks everything: new mode takes effect and fetch restarts at 0.
      if (h_last && v_last) begin
        ang_reg       <= AnG;
        gm_reg        <= mode[3:1];
        line_base_reg <= '0;
        addr_cnt_reg  <= '0;
        rep_cnt_reg   <= '0;
      end else if (line_end) begin
        if (rep_cnt_reg == rep_last) begin
          line_base_reg <= line_base_reg + bpl;
          addr_cnt_reg  <= line_base_reg + bpl;
          rep_cnt_reg   <= 4'd0;
        end else begin
          addr_cnt_reg <= line_base_reg;
          rep_cnt_reg  <= rep_cnt_reg + 4'd1;
        end
      end else if (load_now) begin
        addr_cnt_reg <= addr_cnt_reg + 1'b1;
      end

      load_reg <= load_now;
      row_reg  <= ang_reg ? 4'd0 : rep_cnt_reg;
      addr_reg <= addr_cnt_reg;
      de_reg   <= active;
      hs_n_reg <= ~hsync_on;
      fs_n_reg <= ~fsync_on;
    end
  end

  assign load = load_reg;
  assign row  = row_reg;
  assign addr = addr_reg;
  assign de   = de_reg;
  assign HS_n = hs_n_reg;
  assign FS_n = fs_n_reg;

endmodule

// File: tb/tb_vdg_timing.sv
// Bench for vdg_timing on a scaled-down raster (short fields); a closed-form position
// model predicts every output on every cycle, plus a few hand-computed spot values.
module tb_vdg_timing;

  localparam int HA  = 64;
  localparam int HT  = 96;
  localparam int HSS = 72;
  localparam int HSL = 12;
  localparam int VA  = 48;
  localparam int VT  = 60;
  localparam int VSS = 52;
  localparam int VSL = 3;
  localparam int AW  = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          AnG = 1'b0;
  logic [3:0]    mode = 4'b0000;
  logic          load;
  logic [3:0]    row;
  logic [AW-1:0] addr;
  logic          de;
  logic          HS_n;
  logic          FS_n;

  always #5 clk = ~clk;

  vdg_timing #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .AnG(AnG), .mode(mode),
    .load(load), .row(row), .addr(addr), .de(de), .HS_n(HS_n), .FS_n(FS_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model position: m_h/m_v is the raster position the DUT counters hold now;
  // oh/ov is the position the registered outputs currently describe.
  int m_h = 0, m_v = 0, m_field = 0, f_ang = 0, f_gm = 0;
  int oh = 0, ov = 0, o_ang = 0, o_gm = 0;
  bit out_rst = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at h=%0d v=%0d: got %0d expected %0d", name, oh, ov, act, exp);
    end
  endtask

  function automatic void geom(input int ang, input int gm, output int bpl, output int rep);
    if (ang == 0) begin
      bpl = HA / 8; rep = 12;
    end else begin
      case (gm)
        0, 1:    begin bpl = HA / 16; rep = 3; end
        2:       begin bpl = HA / 8;  rep = 3; end
        3:       begin bpl = HA / 16; rep = 2; end
        4:       begin bpl = HA / 8;  rep = 2; end
        5:       begin bpl = HA / 16; rep = 1; end
        default: begin bpl = HA / 8;  rep = 1; end
      endcase
    end
  endfunction

  // Compare process: advance the model by the edge just taken, then check all outputs.
  initial begin
    int bpl, rep, step, e_de, e_load, e_rc, e_addr, e_row, e_hs, e_fs;
    forever begin
      @(negedge clk);
      if (reset) begin
        out_rst = 1'b1;
        m_h = 0; m_v = 0;
        f_ang = int'(AnG); f_gm = int'(mode[3:1]);
      end else begin
        out_rst = 1'b0;
        oh = m_h; ov = m_v; o_ang = f_ang; o_gm = f_gm;
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin
            m_v = 0; m_field++;
            f_ang = int'(AnG); f_gm = int'(mode[3:1]);
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end

      if (out_rst) begin
        chk("rst_load", int'(load), 0);
        chk("rst_row",  int'(row),  0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_de",   int'(de),   0);
        chk("rst_hs",   int'(HS_n), 1);
        chk("rst_fs",   int'(FS_n), 1);
      end else begin
        geom(o_ang, o_gm, bpl, rep);
        step   = (bpl == HA / 8) ? 8 : 16;
        e_de   = (oh < HA && ov < VA) ? 1 : 0;
        e_load = (e_de == 1 && (oh % step) == 0) ? 1 : 0;
        if (ov < VA) begin
          if (oh < HA) begin
            e_rc   = ov % rep;
            e_addr = (ov / rep) * bpl + (oh + step - 1) / step;
          end else begin
            e_rc   = (ov + 1) % rep;
            e_addr = ((ov + 1) / rep) * bpl;
          end
        end else begin
          e_rc   = 0;
          e_addr = (VA / rep) * bpl;
        end
        e_row = (o_ang == 0) ? e_rc : 0;
        e_hs  = (oh >= HSS && oh < HSS + HSL) ? 0 : 1;
        e_fs  = (ov >= VSS && ov < VSS + VSL) ? 0 : 1;
        chk("de",   int'(de),   e_de);
        chk("load", int'(load), e_load);
        chk("row",  int'(row),  e_row);
        chk("addr", int'(addr), e_addr % (1 << AW));
        chk("hs_n", int'(HS_n), e_hs);
        chk("fs_n", int'(FS_n), e_fs);

        // Hand-computed spot values for this raster (bytes/line: 8 wide, 4 narrow).
        if (oh == 0 && ov == 0) begin
          chk("lit_field_start_addr", int'(addr), 0);
          chk("lit_field_start_load", int'(load), 1);
        end
        if (o_ang == 0 && ov == 11 && oh == 0) chk("lit_alpha_l11_row", int'(row), 11);
        if (o_ang == 0 && ov == 12 && oh == 0) begin
          chk("lit_alpha_l12_addr", int'(addr), 8);
          chk("lit_alpha_l12_row",  int'(row),  0);
        end
        if (o_ang == 0 && ov == 47 && oh == 56) chk("lit_alpha_last_addr", int'(addr), 31);
        if (o_ang == 1 && o_gm == 6 && ov == 10 && oh == 0) chk("lit_gm110_l10_addr", int'(addr), 80);
        if (o_ang == 1 && o_gm == 6 && ov == 47 && oh == 56) chk("lit_gm110_last_addr", int'(addr), 383);
        if (o_ang == 1 && o_gm == 0 && ov == 45 && oh == 0) chk("lit_gm000_l45_addr", int'(addr), 60);
        if (o_ang == 1 && o_gm == 0 && ov == 5 && oh == 8) chk("lit_gm000_no_load_h8", int'(load), 0);
        if (oh == HSS) chk("lit_hs_low_first", int'(HS_n), 0);
        if (oh == HSS + HSL) chk("lit_hs_high_after", int'(HS_n), 1);
        if (ov == VSS && oh == 0) chk("lit_fs_low", int'(FS_n), 0);
        if (ov == VA && oh == 0) chk("lit_blank_de", int'(de), 0);
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < HT * VT + 10; i++) begin
      @(negedge clk); #1;
      if (m_h == h && m_v == v) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_pos timeout: got no match expected h=%0d v=%0d", h, v);
  endtask

  task automatic wait_field(input int f);
    for (int i = 0; i < HT * VT + 10; i++) begin
      @(negedge clk); #1;
      if (m_field == f) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_field timeout: got field %0d expected %0d", m_field, f);
  endtask

  initial begin
    reset = 1'b1; AnG = 1'b0; mode = 4'b0000;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Field 0 alpha; switching to GM110 mid-field must wait for field 1.
    wait_pos(0, 20);
    AnG = 1'b1; mode = 4'b1100;
    wait_field(1);
    wait_pos(0, 20);
    AnG = 1'b1; mode = 4'b0000;
    wait_field(2);
    wait_pos(0, 50);
    AnG = 1'b0; mode = 4'b0000;
    wait_field(3);

    // Mid-frame reset in an alpha field; reset loads GM100 from the inputs.
    wait_pos(40, 30);
    AnG = 1'b1; mode = 4'b1000;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (2000) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
